mcycle_unit: RTL and testbench
==============================

MCYCLE_UNIT -- requirements
Module: mcycle_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand and result width in bits.
REQ-002 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET, input, 1, a synchronous active-high reset.
REQ-004 SHALL have port Start, input, 1, a request to begin an operation.
REQ-005 SHALL have port MCycleOp, input, 2: 00 unsigned mul, 01 signed mul, 10 unsigned div, 11 signed div.
REQ-006 SHALL have ports Operand1 and Operand2, input, WIDTH each: multiplicand/multiplier, or dividend/divisor.
REQ-007 SHALL have port WA3In, input, 4, the destination register tag of the requesting instruction.
REQ-008 SHALL have port Result1, output, WIDTH: product low half, or quotient.
REQ-009 SHALL have port Result2, output, WIDTH: product high half, or remainder.
REQ-010 SHALL have port Busy, output, 1, high while an operation is computing.
REQ-011 SHALL have port Done, output, 1, a one-cycle pulse marking results valid.
REQ-012 SHALL have port MCycleWA3, output, 4, the latched destination tag of the current or last operation.

Function
REQ-013 SHALL implement an FSM with states IDLE, COMPUTE and DONE, registered in a single state register.
REQ-014 In IDLE or DONE, Start=1 at an edge SHALL latch the operands, MCycleOp and WA3In, clear the iteration counter, and enter COMPUTE.
REQ-015 Start SHALL be ignored while in COMPUTE; the latched operands, op and tag SHALL remain unchanged.
REQ-016 COMPUTE SHALL perform exactly one iteration per cycle for WIDTH cycles:
- mul: shift-add
- div: restoring
- On the edge completing iteration WIDTH-1, the FSM SHALL enter DONE.
REQ-017 Busy SHALL be 1 exactly in COMPUTE.
- A Start accepted at edge k gives Busy=1 in the WIDTH cycles between edge k and edge k+WIDTH.
- Done=1 in the cycle between edge k+WIDTH and edge k+WIDTH+1.
REQ-018 DONE SHALL last one cycle, then go to IDLE, unless Start=1, in which case it goes to COMPUTE (back-to-back issue).
REQ-019 Result1/Result2 SHALL update only on the edge entering DONE, and SHALL hold until the next completion.
REQ-020 MCycleWA3 SHALL update only on Start acceptance, and SHALL hold through COMPUTE, DONE and IDLE.
REQ-021 Signed ops SHALL operate on operand magnitudes, with sign correction applied when entering DONE:
- product sign = XOR of the operand signs
- quotient truncates toward zero
- remainder takes the sign of the dividend
REQ-022 Multiplication SHALL produce the full 2*WIDTH-bit result: Result2 = high half, Result1 = low half.
REQ-023 Divide by zero SHALL give Result1 = all ones and Result2 = Operand1 as latched, for both signed and unsigned divide.
REQ-024 Signed overflow (most-negative value / -1) SHALL give Result1 = most-negative value and Result2 = 0.
REQ-025 Operand changes after Start acceptance SHALL NOT affect the result.

Reset
REQ-026 RESET=1 at an edge SHALL force IDLE and clear Busy, Done, Result1, Result2, MCycleWA3 and the counter to 0, regardless of state.
REQ-027 RESET mid-COMPUTE SHALL abandon the operation: no Done pulse, and results remain 0.
REQ-028 RESET SHALL take priority over a simultaneous Start.

Verification
REQ-029 Unsigned mul 0xFFFFFFFF*0xFFFFFFFF, WA3In=5 -> Busy=1 for 32 cycles; Done at edge k+32; Result2=0xFFFFFFFE, Result1=0x00000001; MCycleWA3=5.
REQ-030 Signed mul -3*7 -> Result1=0xFFFFFFEB, Result2=0xFFFFFFFF; signed div -7/2 -> Result1=0xFFFFFFFD, Result2=0xFFFFFFFF.
REQ-031 Unsigned div 5/0 -> Result1=0xFFFFFFFF, Result2=0x00000005; signed div 0x80000000/0xFFFFFFFF -> Result1=0x80000000, Result2=0.
REQ-032 Start pulsed at cycle 10 of a busy operation with new operands and WA3In=9 -> ignored; results and MCycleWA3 reflect the first operation only.
REQ-033 Start held high in the DONE cycle -> new operation accepted; Busy=1 the next cycle; prior results stay visible until the new Done.
REQ-034 RESET asserted for one edge at cycle 12 of COMPUTE -> next cycle Busy=0, Done=0, all outputs 0; no Done pulse appears afterwards.

Source files
------------

// File: rtl/mcycle_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Signed operations run on magnitudes; the sign correction is applied on the edge that enters DONE.
module mcycle_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    input  logic [3:0]       WA3In,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done,
    output logic [3:0]       MCycleWA3
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      count;
    logic               is_div, neg_lo, neg_hi, div_zero;
    logic [WIDTH-1:0]   opnd, dividend;
    logic [2*WIDTH-1:0] acc, acc_next, prod;
    logic [WIDTH-1:0]   mag1, mag2, quo, rem;
    logic [WIDTH:0]     sum, rs, diff;
    logic               s1, s2, accept, last;

    assign accept = Start && (state != COMPUTE);
    assign last   = (state == COMPUTE) && (count == CW'(WIDTH - 1));
    assign Busy   = (state == COMPUTE);
    assign Done   = (state == DONE);

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start) state_next = COMPUTE;
            COMPUTE: if (last)  state_next = DONE;
            DONE:    state_next = Start ? COMPUTE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        s1   = MCycleOp[0] & Operand1[WIDTH-1];
        s2   = MCycleOp[0] & Operand2[WIDTH-1];
        mag1 = s1 ? -Operand1 : Operand1;
        mag2 = s2 ? -Operand2 : Operand2;
    end

    // acc holds {partial product, multiplier} for mul and {remainder, dividend/quotient} for div.
    always_comb begin
        sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
        rs   = acc[2*WIDTH-1:WIDTH-1];
        diff = rs - {1'b0, opnd};
        if (!is_div)
            acc_next = {sum, acc[WIDTH-1:1]};
        else if (diff[WIDTH])
            acc_next = {acc[2*WIDTH-2:0], 1'b0};
        else
            acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        prod = neg_lo ? -acc_next : acc_next;
        quo  = neg_lo ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
        rem  = neg_hi ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            count     <= '0;
            is_div    <= 1'b0;
            neg_lo    <= 1'b0;
            neg_hi    <= 1'b0;
            div_zero  <= 1'b0;
            opnd      <= '0;
            dividend  <= '0;
            acc       <= '0;
            Result1   <= '0;
            Result2   <= '0;
            MCycleWA3 <= '0;
        end else if (accept) begin
            count     <= '0;
            is_div    <= MCycleOp[1];
            neg_lo    <= s1 ^ s2;
            neg_hi    <= MCycleOp[1] & s1;
            div_zero  <= MCycleOp[1] && (Operand2 == '0);
            dividend  <= Operand1;
            MCycleWA3 <= WA3In;
            opnd      <= MCycleOp[1] ? mag2 : mag1;
            acc       <= {{WIDTH{1'b0}}, (MCycleOp[1] ? mag1 : mag2)};
        end else if (state == COMPUTE) begin
            acc   <= acc_next;
            count <= count + CW'(1);
            if (last) begin
                if (!is_div) begin
                    {Result2, Result1} <= prod;
                end else if (div_zero) begin
                    Result1 <= '1;
                    Result2 <= dividend;
                end else begin
                    Result1 <= quo;
                    Result2 <= rem;
                end
            end
        end
    end

endmodule

// File: tb/tb_mcycle_unit.sv
// Self-checking bench for mcycle_unit: directed corner cases plus randomized ops against a
// 64-bit arithmetic reference model.
module tb_mcycle_unit;

    localparam int W = 32;

    logic          CLK = 1'b0;
    logic          RESET, Start;
    logic [1:0]    MCycleOp;
    logic [W-1:0]  Operand1, Operand2, Result1, Result2;
    logic [3:0]    WA3In, MCycleWA3;
    logic          Busy, Done;

    int checks = 0;
    int errors = 0;

    mcycle_unit #(.WIDTH(W)) dut (
        .CLK(CLK), .RESET(RESET), .Start(Start), .MCycleOp(MCycleOp),
        .Operand1(Operand1), .Operand2(Operand2), .WA3In(WA3In),
        .Result1(Result1), .Result2(Result2), .Busy(Busy), .Done(Done),
        .MCycleWA3(MCycleWA3)
    );

    always #5 CLK = ~CLK;

    // Returns {Result2, Result1} computed with plain integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: begin up = {32'b0, a} * {32'b0, b}; return up; end
            2'b01: begin p = sa * sb; return p; end
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Presents a Start for one edge; afterwards the operands are scrambled so late changes are visible.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        @(negedge CLK);
        Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b; WA3In = tag;
        @(negedge CLK);
        Start = 1'b0; Operand1 = $urandom; Operand2 = $urandom; MCycleOp = 2'($urandom); WA3In = 4'($urandom);
    endtask

    task automatic wait_done(output int busy_n, output bit seen);
        busy_n = 0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (Done) seen = 1'b1;
            else begin
                if (Busy) busy_n++;
                @(negedge CLK);
            end
        end
    endtask

    task automatic test_reset;
        RESET = 1'b1; Start = 1'b0; MCycleOp = 2'b00; Operand1 = '0; Operand2 = '0; WA3In = '0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({Busy, Done, Result1, Result2, MCycleWA3} !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b r1=%h r2=%h wa3=%h, want all 0", Busy, Done, Result1, Result2, MCycleWA3);
        end
        RESET = 1'b0;
    endtask

    task automatic test_mul_max;
        int n; bit seen;
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5);
        wait_done(n, seen);
        checks++;
        if (!seen || n != 32) begin
            errors++; $display("FAIL mul_max_timing: busy_cycles=%0d done=%b, want 32 and 1", n, seen);
        end
        checks++;
        if ({Result2, Result1} !== 64'hFFFF_FFFE_0000_0001 || MCycleWA3 !== 4'd5) begin
            errors++; $display("FAIL mul_max_result: r2=%h r1=%h wa3=%0d, want fffffffe 00000001 5", Result2, Result1, MCycleWA3);
        end
        @(negedge CLK);
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b0 || Result1 !== 32'h1 || MCycleWA3 !== 4'd5) begin
            errors++; $display("FAIL done_one_cycle: done=%b busy=%b r1=%h wa3=%0d, want 0 0 1 5", Done, Busy, Result1, MCycleWA3);
        end
    endtask

    task automatic test_signed;
        int n; bit seen;
        issue(2'b01, -32'sd3, 32'sd7, 4'd1);
        wait_done(n, seen);
        checks++;
        if (!seen || Result1 !== 32'hFFFF_FFEB || Result2 !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL smul_m3x7: r1=%h r2=%h, want ffffffeb ffffffff", Result1, Result2);
        end
        issue(2'b11, -32'sd7, 32'sd2, 4'd2);
        wait_done(n, seen);
        checks++;
        if (!seen || Result1 !== 32'hFFFF_FFFD || Result2 !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL sdiv_m7d2: r1=%h r2=%h, want fffffffd ffffffff", Result1, Result2);
        end
    endtask

    task automatic test_div_special;
        int n; bit seen;
        logic [31:0] a_t [3] = '{32'd5, 32'h8000_0000, 32'hFFFF_FFF7};
        logic [31:0] b_t [3] = '{32'd0, 32'hFFFF_FFFF, 32'd0};
        logic [1:0]  o_t [3] = '{2'b10, 2'b11, 2'b11};
        logic [63:0] e_t [3] = '{64'h0000_0005_FFFF_FFFF, 64'h0000_0000_8000_0000, 64'hFFFF_FFF7_FFFF_FFFF};
        for (int i = 0; i < 3; i++) begin
            issue(o_t[i], a_t[i], b_t[i], 4'(i + 3));
            wait_done(n, seen);
            checks++;
            if (!seen || {Result2, Result1} !== e_t[i]) begin
                errors++; $display("FAIL div_special_%0d: r2:r1=%h, want %h", i, {Result2, Result1}, e_t[i]);
            end
        end
    endtask

    task automatic test_random;
        int n; bit seen;
        logic [1:0] op; logic [31:0] a, b; logic [3:0] tag; logic [63:0] exp;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom); tag = 4'($urandom);
            a = (i % 4 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            b = (i % 5 == 0) ? 32'($urandom_range(0, 3)) : ((i % 3 == 0) ? -32'($urandom_range(1, 9)) : $urandom);
            exp = model(op, a, b);
            issue(op, a, b, tag);
            wait_done(n, seen);
            checks++;
            if (!seen || n != 32 || {Result2, Result1} !== exp || MCycleWA3 !== tag) begin
                errors++;
                $display("FAIL random_%0d: op=%b a=%h b=%h got %h wa3=%0d busy=%0d, want %h wa3=%0d busy=32",
                         i, op, a, b, {Result2, Result1}, MCycleWA3, n, exp, tag);
            end
        end
    endtask

    task automatic test_start_ignored;
        int n; bit seen; logic [63:0] exp;
        exp = model(2'b01, 32'd1234, -32'd77);
        issue(2'b01, 32'd1234, -32'd77, 4'd3);
        repeat (9) @(negedge CLK);
        Start = 1'b1; MCycleOp = 2'b00; Operand1 = 32'd99; Operand2 = 32'd99; WA3In = 4'd9;
        @(negedge CLK);
        Start = 1'b0;
        checks++;
        if (Busy !== 1'b1 || MCycleWA3 !== 4'd3) begin
            errors++; $display("FAIL start_ignored_mid: busy=%b wa3=%0d, want 1 3", Busy, MCycleWA3);
        end
        wait_done(n, seen);
        checks++;
        if (!seen || n != 22 || {Result2, Result1} !== exp || MCycleWA3 !== 4'd3) begin
            errors++; $display("FAIL start_ignored_result: got %h wa3=%0d busy=%0d, want %h 3 22", {Result2, Result1}, MCycleWA3, n, exp);
        end
        @(negedge CLK);
        checks++;
        if (Busy !== 1'b0) begin
            errors++; $display("FAIL start_ignored_idle: busy=%b, want 0", Busy);
        end
    endtask

    task automatic test_back_to_back;
        int n; bit seen; logic [63:0] ea, eb;
        ea = model(2'b10, 32'd1000, 32'd7);
        eb = model(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
        issue(2'b10, 32'd1000, 32'd7, 4'd6);
        wait_done(n, seen);
        checks++;
        if (!seen || {Result2, Result1} !== ea) begin
            errors++; $display("FAIL b2b_first: got %h, want %h", {Result2, Result1}, ea);
        end
        Start = 1'b1; MCycleOp = 2'b00; Operand1 = 32'h1234_5678; Operand2 = 32'h9ABC_DEF0; WA3In = 4'd11;
        @(negedge CLK);
        Start = 1'b0; Operand1 = $urandom; Operand2 = $urandom;
        checks++;
        if (Busy !== 1'b1 || Done !== 1'b0 || {Result2, Result1} !== ea || MCycleWA3 !== 4'd11) begin
            errors++; $display("FAIL b2b_accept: busy=%b done=%b res=%h wa3=%0d, want 1 0 %h 11", Busy, Done, {Result2, Result1}, MCycleWA3, ea);
        end
        wait_done(n, seen);
        checks++;
        if (!seen || n != 32 || {Result2, Result1} !== eb) begin
            errors++; $display("FAIL b2b_second: got %h busy=%0d, want %h 32", {Result2, Result1}, n, eb);
        end
    endtask

    task automatic test_reset_mid;
        int dones = 0;
        issue(2'b00, 32'd12345, 32'd678, 4'd7);
        repeat (11) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        checks++;
        if ({Busy, Done, Result1, Result2, MCycleWA3} !== '0) begin
            errors++; $display("FAIL reset_mid: busy=%b done=%b r1=%h r2=%h wa3=%h, want all 0", Busy, Done, Result1, Result2, MCycleWA3);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (Done || Busy) dones++;
        end
        checks++;
        if (dones != 0 || Result1 !== '0 || Result2 !== '0) begin
            errors++; $display("FAIL reset_mid_after: active_cycles=%0d r1=%h r2=%h, want 0 0 0", dones, Result1, Result2);
        end
        RESET = 1'b1; Start = 1'b1; MCycleOp = 2'b00; Operand1 = 32'd3; Operand2 = 32'd3; WA3In = 4'd8;
        @(negedge CLK);
        RESET = 1'b0; Start = 1'b0;
        checks++;
        if (Busy !== 1'b0 || MCycleWA3 !== 4'd0) begin
            errors++; $display("FAIL reset_priority: busy=%b wa3=%0d, want 0 0", Busy, MCycleWA3);
        end
    endtask

    initial begin
        test_reset;
        test_mul_max;
        test_signed;
        test_div_special;
        test_random;
        test_start_ignored;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
